// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event generator: per-channel FSM states
// and the ms-to-clock-cycle conversion used to size the debounce and hold timers.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } key_state_e;

    function automatic int unsigned ms_to_cyc(input int unsigned clk_freq, input int unsigned ms);
        return clk_freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, press/release/toggle events.
// Long-press detection (hold counter + O_long) is built only with KEY_EVENT_LONG_PRESS_EN.
module key_event_chan
    import key_event_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 27_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 500,
    parameter int          ACTIVE_LOW  = 1
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_key,
    output logic       O_key_level,
    output logic       O_press,
    output logic       O_release,
    output logic       O_long,
    output logic       O_toggle,
    output key_state_e O_state
);

    localparam int unsigned DEB_CYC  = ms_to_cyc(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cyc(CLK_FREQ, LONG_MS);
    localparam int unsigned MAX_CYC  = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
    localparam int          CNT_W    = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] DEB_CYC_W = CNT_W'(DEB_CYC);
    // Raw pin level that means "not pressed"; the synchroniser resets to it.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    logic [1:0]       sync;
    logic             key_s;
    key_state_e       state, state_nxt;
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_clr, deb_inc;
    logic             press_nxt, release_nxt;
    logic             press_q, release_q, level_q, toggle_q;

    assign key_s = sync[1] ^ IDLE_LVL;

    always_comb begin
        state_nxt   = state;
        deb_clr     = 1'b0;
        deb_inc     = 1'b0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) begin
                    state_nxt = DEB_PRESS;
                    deb_clr   = 1'b1;
                end
            end
            DEB_PRESS: begin
                if (!key_s) begin
                    state_nxt = IDLE;
                end else if (deb_cnt >= DEB_CYC_W) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    state_nxt = DEB_RELEASE;
                    deb_clr   = 1'b1;
                end
            end
            DEB_RELEASE: begin
                if (key_s) begin
                    state_nxt = PRESSED;
                end else if (deb_cnt >= DEB_CYC_W) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else begin
                    deb_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            sync      <= {2{IDLE_LVL}};
            state     <= IDLE;
            deb_cnt   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            sync      <= {sync[0], I_key};
            state     <= state_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            if (deb_clr) begin
                deb_cnt <= '0;
            end else if (deb_inc) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            if (press_nxt) begin
                level_q  <= 1'b1;
                toggle_q <= ~toggle_q;
            end else if (release_nxt) begin
                level_q <= 1'b0;
            end
        end
    end

`ifdef KEY_EVENT_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_CYC_W = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYC - 1);

    logic [CNT_W-1:0] hold_cnt;
    logic             long_done, long_q, long_hit;

    // Hold time keeps running through DEB_RELEASE, but the event only fires in PRESSED.
    assign long_hit = (state == PRESSED) && !long_done && (hold_cnt >= LONG_LAST);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            long_q <= long_hit;
            if (press_nxt) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else begin
                if ((state == PRESSED || state == DEB_RELEASE) && hold_cnt < LONG_CYC_W) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                if (long_hit) begin
                    long_done <= 1'b1;
                end
            end
        end
    end

    assign O_long = long_q;
`else
    assign O_long = 1'b0;
`endif

    assign O_key_level = level_q;
    assign O_press     = press_q;
    assign O_release   = release_q;
    assign O_toggle    = toggle_q;
    assign O_state     = state;

endmodule

// File: rtl/key_event_gen.sv
// KEY_NUM independent debounced key channels with press/release/long/toggle events.
// Define KEY_EVENT_LONG_PRESS_EN to build the long-press hold counters.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 27_000_000,
    parameter int          KEY_NUM     = 4,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 500,
    parameter int          ACTIVE_LOW  = 1
) (
    input  logic                                  I_clk,
    input  logic                                  I_rst_n,
    input  logic [KEY_NUM-1:0]                    I_key,
    output logic [KEY_NUM-1:0]                    O_key_level,
    output logic [KEY_NUM-1:0]                    O_press,
    output logic [KEY_NUM-1:0]                    O_release,
    output logic [KEY_NUM-1:0]                    O_long,
    output logic [KEY_NUM-1:0]                    O_toggle,
    output logic [KEY_NUM*$bits(key_state_e)-1:0] O_dbg_state
);

    localparam int STATE_W = $bits(key_state_e);

    key_state_e chan_state [KEY_NUM];

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
        key_event_chan #(
            .CLK_FREQ   (CLK_FREQ),
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .I_clk      (I_clk),
            .I_rst_n    (I_rst_n),
            .I_key      (I_key[i]),
            .O_key_level(O_key_level[i]),
            .O_press    (O_press[i]),
            .O_release  (O_release[i]),
            .O_long     (O_long[i]),
            .O_toggle   (O_toggle[i]),
            .O_state    (chan_state[i])
        );
        assign O_dbg_state[i*STATE_W +: STATE_W] = chan_state[i];
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed event timings.
module tb_key_event_gen;

    localparam int KN       = 2;
    localparam int DEB_CYC  = 5;
    localparam int LONG_CYC = 20;
    localparam int LAT      = DEB_CYC + 3;

    logic          I_clk   = 1'b0;
    logic          I_rst_n = 1'b0;
    logic [KN-1:0] I_key   = 2'b11;
    logic [KN-1:0] O_key_level, O_press, O_release, O_long, O_toggle;
    logic [2*KN-1:0] O_dbg_state;

    key_event_gen #(
        .CLK_FREQ   (1000),
        .KEY_NUM    (KN),
        .DEBOUNCE_MS(5),
        .LONG_MS    (20),
        .ACTIVE_LOW (1)
    ) dut (
        .I_clk      (I_clk),
        .I_rst_n    (I_rst_n),
        .I_key      (I_key),
        .O_key_level(O_key_level),
        .O_press    (O_press),
        .O_release  (O_release),
        .O_long     (O_long),
        .O_toggle   (O_toggle),
        .O_dbg_state(O_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 I_clk = ~I_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A channel flips its accepted level once the synchronised input has disagreed
    // with it for DEB_CYC+2 consecutive samples (= DEB_CYC+3 edges incl. sync).
    logic [2*KN*5-1:0] exp_q[$];
    logic m_s1 [KN], m_s2 [KN], m_level [KN], m_toggle [KN], m_long_done [KN];
    int   m_run [KN], m_press_cyc [KN];

    always @(posedge I_clk) begin : model
        logic s;
        logic [KN-1:0] el, ep, er, elg, et;
        cyc++;
        el = '0; ep = '0; er = '0; elg = '0; et = '0;
        for (int c = 0; c < KN; c++) begin
            if (!I_rst_n) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_level[c] = 1'b0; m_toggle[c] = 1'b0;
                m_long_done[c] = 1'b0; m_run[c] = 0; m_press_cyc[c] = 0;
            end else begin
                s = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = ~I_key[c];
`ifdef KEY_EVENT_LONG_PRESS_EN
                if (m_level[c] && m_run[c] == 0 && !m_long_done[c] &&
                    (cyc - m_press_cyc[c]) >= LONG_CYC) begin
                    elg[c] = 1'b1;
                    m_long_done[c] = 1'b1;
                end
`endif
                if (s != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB_CYC + 2) begin
                        m_run[c] = 0;
                        m_level[c] = s;
                        if (s) begin
                            ep[c] = 1'b1;
                            m_toggle[c] = ~m_toggle[c];
                            m_press_cyc[c] = cyc;
                            m_long_done[c] = 1'b0;
                        end else begin
                            er[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                el[c] = m_level[c];
                et[c] = m_toggle[c];
            end
        end
        exp_q.push_back({el, ep, er, elg, et});
    end

    // ---------------- scoreboard / monitor ----------------
    int last_press [KN], last_release [KN], last_long [KN];
    int n_press [KN], n_release [KN], n_long [KN];
    int both_press = 0;

    always @(posedge I_clk) begin : compare
        logic [2*KN*5-1:0] e;
        #1;
        if (exp_q.size() == 0) begin
            chk("exp_q_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("level",   32'(O_key_level), 32'(e[9:8]));
            chk("press",   32'(O_press),     32'(e[7:6]));
            chk("release", 32'(O_release),   32'(e[5:4]));
            chk("long",    32'(O_long),      32'(e[3:2]));
            chk("toggle",  32'(O_toggle),    32'(e[1:0]));
        end
        for (int c = 0; c < KN; c++) begin
            if (O_press[c])   begin n_press[c]++;   last_press[c]   = cyc; end
            if (O_release[c]) begin n_release[c]++; last_release[c] = cyc; end
            if (O_long[c])    begin n_long[c]++;    last_long[c]    = cyc; end
        end
        if (O_press == 2'b11) both_press++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge I_clk);
    endtask

    // Park at the negedge just before the posedge numbered 'first'.
    task automatic goto_first(input int first);
        for (int i = 0; i < 2000 && cyc < first - 1; i++) @(negedge I_clk);
        if (cyc != first - 1) chk("goto_timeout", 32'(cyc), 32'(first - 1));
    endtask

    // Call at a negedge; returns the first posedge that samples the new level.
    task automatic drive_key(input int c, input logic v, output int first);
        I_key[c] = v;
        first = cyc + 1;
    endtask

    task automatic do_reset();
        I_rst_n = 1'b0;
        wait_cyc(3);
        I_rst_n = 1'b1;
        wait_cyc(2);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int st, p, rel, np0, nl0, nr0;

        wait_cyc(3);
        chk("rst_level",  32'(O_key_level), 32'd0);
        chk("rst_toggle", 32'(O_toggle),    32'd0);
        chk("rst_state",  32'(O_dbg_state), 32'd0);
        I_rst_n = 1'b1;
        wait_cyc(3);

        // Clean press of key0, held for 30 cycles past the press pulse, then released.
        np0 = n_press[0]; nl0 = n_long[0]; nr0 = n_release[0];
        drive_key(0, 1'b0, st);
        wait_cyc(LAT + 3);
        p = st + LAT;
        chk("press_lat",    32'(last_press[0]), 32'(p));
        chk("press_count",  32'(n_press[0] - np0), 32'd1);
        chk("press_level",  32'(O_key_level[0]), 32'd1);
        chk("press_toggle", 32'(O_toggle[0]), 32'd1);
        goto_first(p + 30);
        drive_key(0, 1'b1, rel);
        wait_cyc(LAT + 3);
`ifdef KEY_EVENT_LONG_PRESS_EN
        chk("long_count", 32'(n_long[0] - nl0), 32'd1);
        chk("long_lat",   32'(last_long[0]), 32'(p + LONG_CYC));
`else
        chk("long_count", 32'(n_long[0] - nl0), 32'd0);
`endif
        chk("release_lat",   32'(last_release[0]), 32'(rel + LAT));
        chk("release_count", 32'(n_release[0] - nr0), 32'd1);
        chk("release_level", 32'(O_key_level[0]), 32'd0);

        // Bounce: low 3, high 1, then low and held; only the final edge counts.
        np0 = n_press[0];
        drive_key(0, 1'b0, st);
        wait_cyc(3);
        drive_key(0, 1'b1, st);
        wait_cyc(1);
        drive_key(0, 1'b0, st);
        wait_cyc(LAT + 3);
        chk("bounce_count", 32'(n_press[0] - np0), 32'd1);
        chk("bounce_lat",   32'(last_press[0]), 32'(st + LAT));
        drive_key(0, 1'b1, st);
        wait_cyc(LAT + 3);

        // Simultaneous press on both keys from a clean reset, then key1 alone.
        do_reset();
        I_key = 2'b00;
        st = cyc + 1;
        wait_cyc(LAT + 3);
        chk("both_press_cycles", 32'(both_press), 32'd1);
        chk("both_press_lat",    32'(last_press[1]), 32'(st + LAT));
        chk("both_toggle",       32'(O_toggle), 32'd3);
        I_key = 2'b11;
        wait_cyc(LAT + 3);
        chk("both_release_level", 32'(O_key_level), 32'd0);
        drive_key(1, 1'b0, st);
        wait_cyc(LAT + 3);
        chk("key1_toggle", 32'(O_toggle), 32'd1);
        chk("key1_level",  32'(O_key_level), 32'd2);

        // Reset while key0 is debouncing and key1 is pressed; both held through reset.
        np0 = n_press[0];
        drive_key(0, 1'b0, st);
        wait_cyc(4);
        I_rst_n = 1'b0;
        #1;
        chk("midrst_level",  32'(O_key_level), 32'd0);
        chk("midrst_toggle", 32'(O_toggle),    32'd0);
        chk("midrst_press",  32'(O_press),     32'd0);
        chk("midrst_state",  32'(O_dbg_state), 32'd0);
        wait_cyc(3);
        I_rst_n = 1'b1;
        st = cyc + 1;
        wait_cyc(LAT + 3);
        chk("postrst_count", 32'(n_press[0] - np0), 32'd1);
        chk("postrst_lat",   32'(last_press[0]), 32'(st + LAT));
        chk("postrst_level", 32'(O_key_level), 32'd3);

        I_key = 2'b11;
        wait_cyc(LAT + 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 Parameter CLK_FREQ, default 27_000_000, input clock frequency in Hz.
REQ-002 Parameter KEY_NUM, default 4, number of independent key channels (1..16).
REQ-003 Parameter DEBOUNCE_MS, default 20, stable time in ms before a level change is accepted.
REQ-004 Parameter LONG_MS, default 500, hold time in ms before a long-press event.
REQ-005 Parameter ACTIVE_LOW, default 1; 1 means raw key low = pressed.
REQ-006 I_clk  input  1  single clock; all logic on its rising edge.
REQ-007 I_rst_n  input  1  reset; asynchronous, active-low.
REQ-008 I_key  input  KEY_NUM  raw asynchronous key pins, one bit per channel.
REQ-009 O_key_level  output  KEY_NUM  debounced level; 1 = pressed.
REQ-010 O_press  output  KEY_NUM  one-cycle pulse on accepted press.
REQ-011 O_release  output  KEY_NUM  one-cycle pulse on accepted release.
REQ-012 O_long  output  KEY_NUM  one-cycle pulse once per press when hold reaches LONG_MS.
REQ-013 O_toggle  output  KEY_NUM  level that inverts on every accepted press.

Function
REQ-014 Each bit of I_key SHALL pass through a 2-flop synchroniser, then be normalised to pressed = 1 according to ACTIVE_LOW.
REQ-015 DEB_CYC = CLK_FREQ/1000*DEBOUNCE_MS and LONG_CYC = CLK_FREQ/1000*LONG_MS; counter widths SHALL be $clog2 of the larger value plus 1, with no overflow.
REQ-016 Each channel SHALL run an FSM with states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
REQ-017 IDLE -> DEB_PRESS when the synchronised key is 1; the counter is cleared.
REQ-018 In DEB_PRESS, a synchronised 0 SHALL return the FSM to IDLE with no event; after DEB_CYC consecutive 1 samples it SHALL go to PRESSED.
REQ-019 On entering PRESSED the channel SHALL assert O_press for exactly one cycle, set O_key_level, and invert O_toggle in the same cycle.
REQ-020 In PRESSED, a 0 SHALL go to DEB_RELEASE; the hold counter keeps counting but the long event is suppressed until the FSM returns to PRESSED.
REQ-021 In DEB_RELEASE, a 1 SHALL return the FSM to PRESSED without a new O_press; after DEB_CYC consecutive 0 samples it SHALL go to IDLE, assert O_release for one cycle, and clear O_key_level.
REQ-022 Latency: a clean edge on I_key SHALL produce O_press or O_release exactly DEB_CYC+3 cycles after the first sampling edge that sees the new level.
REQ-023 O_long SHALL pulse once when the hold counter reaches LONG_CYC while in PRESSED; the counter saturates, so there is no repeat until the next press.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-025 O_press and O_release of one channel SHALL never be asserted in the same cycle.

Reset
REQ-026 While I_rst_n = 0, all FSMs SHALL be in IDLE, counters and synchroniser flops cleared to "not pressed", and O_key_level, O_press, O_release, O_long and O_toggle all 0.
REQ-027 Reset asserted mid-press SHALL discard any pending event; a key held through reset release SHALL be debounced again and SHALL produce O_press.

Configuration
REQ-028 Macro KEY_EVENT_LONG_PRESS_EN: when defined, the hold counter and O_long logic are built as in REQ-023.
REQ-029 When KEY_EVENT_LONG_PRESS_EN is not defined, O_long SHALL be tied to 0, no hold counter SHALL be synthesised, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package key_event_pkg SHALL hold the FSM state enum (IDLE, DEB_PRESS, PRESSED, DEB_RELEASE) and the ms-to-cycle conversion function.
REQ-031 Sub-module key_event_chan SHALL implement one channel (synchroniser, FSM, counters); key_event_gen SHALL instantiate KEY_NUM copies in a generate loop.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=5, LONG_MS=20, KEY_NUM=2, ACTIVE_LOW=1)
REQ-032 Key0 driven low and held -> O_press[0] pulses 8 cycles after the first sample, O_key_level[0]=1, O_toggle[0] 0->1.
REQ-033 Key0 bounces low 3 cycles, high 1, low 3 -> no O_press; then held low -> O_press 8 cycles after the final low edge.
REQ-034 Key0 held low for 30 cycles after O_press -> exactly one O_long[0] pulse, 20 cycles after O_press; then released -> O_release 8 cycles after the release edge.
REQ-035 Both keys pressed in the same cycle -> O_press=2'b11 in one cycle; a second press of key1 only -> O_toggle=2'b01.
REQ-036 Reset asserted while key0 is in DEB_PRESS -> all outputs 0 immediately; key held through reset release -> O_press 8 cycles after I_rst_n rises.
REQ-037 Build without KEY_EVENT_LONG_PRESS_EN, repeat REQ-034 -> O_long stays 0; O_press and O_release timing unchanged.
